// File: rtl/eth_tx_fcs_framer_if.sv
// Upstream byte stream into the transmit framer: MAC header and payload bytes
// with a valid/ready handshake and an end-of-frame marker.
interface eth_tx_fcs_framer_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;

   modport master (output s_data, output s_valid, output s_last, input s_ready);
   modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/eth_tx_fcs_framer.sv
// GMII transmit framer: preamble, SFD, data, zero pad, FCS and inter-frame gap,
// with the running CRC-32 register and its per-byte step function.
module eth_tx_fcs_framer #(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_FRAME    = 60,
   parameter int IFG_CYCLES   = 12
) (
   input  logic                eth_tx_clk,
   input  logic                sys_rst,
   eth_tx_fcs_framer_if.slave  up,
   output logic [7:0]          gmii_txd,
   output logic                gmii_tx_en,
   output logic                gmii_tx_er,
   output logic                tx_done,
   output logic                tx_underrun
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PREAMBLE = 3'd1,
      SFD      = 3'd2,
      DATA     = 3'd3,
      PAD      = 3'd4,
      FCS      = 3'd5,
      IFG      = 3'd6
   } state_t;

   // IDLE emits the first preamble byte itself, so PREAMBLE covers the rest.
   localparam logic [15:0] PRE_LAST   = 16'(PREAMBLE_LEN - 2);
   localparam logic [15:0] IFG_LAST   = 16'(IFG_CYCLES - 1);
   localparam logic [11:0] MIN_LEN    = 12'(MIN_FRAME);
   localparam state_t      AFTER_IDLE = (PREAMBLE_LEN > 1) ? PREAMBLE : SFD;
   localparam state_t      AFTER_FCS  = (IFG_CYCLES > 0) ? IFG : IDLE;

   function automatic logic [7:0] bitrev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = b[7 - i];
      end
      return r;
   endfunction

   // MSB-first CRC-32 step; callers bit-reverse bytes so bit 0 enters first.
   function automatic logic [31:0] crc32_step(input logic [7:0] din, input logic [31:0] pre_crc);
      logic [31:0] c;
      c = pre_crc;
      for (int i = 7; i >= 0; i--) begin
         if (c[31] ^ din[i]) begin
            c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
         end else begin
            c = {c[30:0], 1'b0};
         end
      end
      return c;
   endfunction

   state_t      state_r, state_nxt_s;
   logic [15:0] cnt_r, cnt_nxt_s;
   logic [10:0] byte_cnt_r, byte_cnt_nxt_s, byte_cnt_sat_s;
   logic [11:0] byte_cnt_inc_s;
   logic [31:0] crc_r, pre_crc_s, step_out_s, crc_sh_s;
   logic [7:0]  data_in_s, fcs_byte_s;
   logic        crc_en_s, crc_load_s;
   logic [7:0]  txd_s;
   logic        en_s, er_s, done_s, underrun_s;

   assign up.s_ready     = (state_r == DATA);
   assign data_in_s      = bitrev8((state_r == PAD) ? 8'h00 : up.s_data);
   assign pre_crc_s      = crc_r;
   assign step_out_s     = crc32_step(data_in_s, pre_crc_s);
   assign byte_cnt_inc_s = {1'b0, byte_cnt_r} + 12'd1;
   assign byte_cnt_sat_s = (byte_cnt_r == 11'h7FF) ? byte_cnt_r : byte_cnt_r + 11'd1;
   assign crc_sh_s       = crc_r << {cnt_r[1:0], 3'b000};
   assign fcs_byte_s     = ~bitrev8(crc_sh_s[31:24]);

   // Next-state and next-output decode for the framing sequence.
   always_comb begin
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
      byte_cnt_nxt_s = byte_cnt_r;
      crc_en_s       = 1'b0;
      crc_load_s     = 1'b0;
      txd_s          = 8'h00;
      en_s           = 1'b0;
      er_s           = 1'b0;
      done_s         = 1'b0;
      underrun_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (up.s_valid) begin
               state_nxt_s    = AFTER_IDLE;
               crc_load_s     = 1'b1;
               byte_cnt_nxt_s = 11'd0;
               cnt_nxt_s      = 16'd0;
               txd_s          = 8'h55;
               en_s           = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         PREAMBLE: begin
            txd_s = 8'h55;
            en_s  = 1'b1;
            if (cnt_r == PRE_LAST) begin
               state_nxt_s = SFD;
               cnt_nxt_s   = 16'd0;
            end else begin
               cnt_nxt_s = cnt_r + 16'd1;
            end
         end
         SFD: begin
            txd_s       = 8'hD5;
            en_s        = 1'b1;
            state_nxt_s = DATA;
         end
         DATA: begin
            en_s      = 1'b1;
            cnt_nxt_s = 16'd0;
            if (up.s_valid) begin
               txd_s          = up.s_data;
               crc_en_s       = 1'b1;
               byte_cnt_nxt_s = byte_cnt_sat_s;
               if (up.s_last) begin
                  state_nxt_s = (byte_cnt_inc_s < MIN_LEN) ? PAD : FCS;
               end else begin
                  state_nxt_s = DATA;
               end
            end else begin
               // Starved mid-frame: mark the byte bad and drop the FCS.
               er_s        = 1'b1;
               underrun_s  = 1'b1;
               state_nxt_s = AFTER_FCS;
            end
         end
         PAD: begin
            en_s           = 1'b1;
            crc_en_s       = 1'b1;
            byte_cnt_nxt_s = byte_cnt_sat_s;
            cnt_nxt_s      = 16'd0;
            if (byte_cnt_inc_s >= MIN_LEN) begin
               state_nxt_s = FCS;
            end else begin
               state_nxt_s = PAD;
            end
         end
         FCS: begin
            txd_s = fcs_byte_s;
            en_s  = 1'b1;
            if (cnt_r[1:0] == 2'd3) begin
               done_s      = 1'b1;
               state_nxt_s = AFTER_FCS;
               cnt_nxt_s   = 16'd0;
            end else begin
               cnt_nxt_s = cnt_r + 16'd1;
            end
         end
         IFG: begin
            if (cnt_r == IFG_LAST) begin
               state_nxt_s = IDLE;
               cnt_nxt_s   = 16'd0;
            end else begin
               cnt_nxt_s = cnt_r + 16'd1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 16'd0;
         end
      endcase
   end

   // State, counters, CRC register and registered GMII outputs.
   always_ff @(posedge eth_tx_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_r     <= IDLE;
         cnt_r       <= 16'd0;
         byte_cnt_r  <= 11'd0;
         crc_r       <= 32'hFFFF_FFFF;
         gmii_txd    <= 8'h00;
         gmii_tx_en  <= 1'b0;
         gmii_tx_er  <= 1'b0;
         tx_done     <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         byte_cnt_r <= byte_cnt_nxt_s;
         if (crc_load_s) begin
            crc_r <= 32'hFFFF_FFFF;
         end else if (crc_en_s) begin
            crc_r <= step_out_s;
         end else begin
            crc_r <= crc_r;
         end
         gmii_txd    <= txd_s;
         gmii_tx_en  <= en_s;
         gmii_tx_er  <= er_s;
         tx_done     <= done_s;
         tx_underrun <= underrun_s;
      end
   end

endmodule

// File: tb/tb_eth_tx_fcs_framer.sv
// Self-checking bench for eth_tx_fcs_framer: random frames scored against a
// reflected CRC-32 model of the expected GMII byte stream.
`timescale 1ns/1ps
module tb_eth_tx_fcs_framer;
   localparam int PRE = 7;
   localparam int MIN = 60;
   localparam int IFG = 12;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic sys_rst = 1'b1;
   always #4 clk = ~clk;

   eth_tx_fcs_framer_if bus0();
   eth_tx_fcs_framer_if bus1();

   logic [7:0] g_txd, g1_txd;
   logic       g_en, g_er, g_done, g_und;
   logic       g1_en, g1_er, g1_done, g1_und;

   eth_tx_fcs_framer #(.PREAMBLE_LEN(PRE), .MIN_FRAME(MIN), .IFG_CYCLES(IFG)) u_dut (
      .eth_tx_clk(clk), .sys_rst(sys_rst), .up(bus0),
      .gmii_txd(g_txd), .gmii_tx_en(g_en), .gmii_tx_er(g_er),
      .tx_done(g_done), .tx_underrun(g_und));

   eth_tx_fcs_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(1), .IFG_CYCLES(12)) u_dut1 (
      .eth_tx_clk(clk), .sys_rst(sys_rst), .up(bus1),
      .gmii_txd(g1_txd), .gmii_tx_en(g1_en), .gmii_tx_er(g1_er),
      .tx_done(g1_done), .tx_underrun(g1_und));

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Reflected (LSB-first) CRC-32 register after the bytes from index start on.
   function automatic logic [31:0] crc_raw(input bq_t b, input int start);
      logic [31:0] r;
      r = 32'hFFFF_FFFF;
      for (int i = start; i < b.size(); i++) begin
         r = r ^ {24'h0, b[i]};
         for (int j = 0; j < 8; j++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
         end
      end
      return r;
   endfunction

   logic [10:0] exp_q[$];
   int          exp_gap[$];
   bq_t         cur;
   bit          in_frame = 1'b0;
   bit          saw_done = 1'b0;
   int          idle_run = 0;

   task automatic rand_bytes(input int n, output bq_t d);
      d = {};
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
   endtask

   task automatic push_exp(input bq_t d, input int mode, input int cut, input int gap);
      bq_t f;
      logic [31:0] c;
      exp_gap.push_back(gap);
      for (int i = 0; i < PRE; i++) exp_q.push_back({3'b000, 8'h55});
      exp_q.push_back({3'b000, 8'hD5});
      if (mode == 1) begin
         for (int i = 0; i < cut; i++) exp_q.push_back({3'b000, d[i]});
         exp_q.push_back({1'b1, 1'b0, 1'b1, 8'h00});
      end else begin
         f = d;
         while (f.size() < MIN) f.push_back(8'h00);
         foreach (f[i]) exp_q.push_back({3'b000, f[i]});
         c = ~crc_raw(f, 0);
         for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, (k == 3), 1'b0, c[8*k +: 8]});
      end
   endtask

   // Wire monitor: scores every tx_en byte, idle flags, gaps and FCS residue.
   always @(negedge clk) begin : mon
      logic [31:0] r, v;
      int g;
      if (sys_rst) begin
         in_frame = 1'b0;
         idle_run = 0;
         cur.delete();
      end else if (g_en) begin
         if (!in_frame) begin
            in_frame = 1'b1;
            saw_done = 1'b0;
            cur.delete();
            if (exp_gap.size() > 0) begin
               g = exp_gap.pop_front();
               if (g >= 0) check_val("ifg_gap", 32'(idle_run), 32'(g));
            end
         end
         if (exp_q.size() > 0) check_val("wire", {21'h0, g_und, g_done, g_er, g_txd}, {21'h0, exp_q.pop_front()});
         else check_val("extra_byte", {21'h0, g_und, g_done, g_er, g_txd}, 32'hFFFF_FFFF);
         cur.push_back(g_txd);
         if (g_done) saw_done = 1'b1;
      end else begin
         check_val("idle_flags", {29'h0, g_er, g_done, g_und}, 32'h0);
         if (in_frame) begin
            in_frame = 1'b0;
            idle_run = 0;
            if (saw_done) begin
               r = crc_raw(cur, PRE + 1);
               for (int j = 0; j < 32; j++) v[j] = r[31 - j];
               check_val("residue", v, 32'hC704_DD7B);
            end
         end
         idle_run++;
      end
   end

   task automatic send_frame(input bq_t d, input int mode, input int cut, input bit hold, input bit chk_lat);
      int i = 0;
      int guard = 0;
      bit hs;
      bit fin = 1'b0;
      bus0.s_valid = 1'b1;
      bus0.s_data  = d[0];
      bus0.s_last  = (d.size() == 1);
      while (!fin && guard < 5000) begin
         @(negedge clk);
         if (chk_lat && guard == 1) check_val("start_lat", {23'h0, g_en, g_txd}, {23'h0, 1'b1, 8'h55});
         hs = bus0.s_ready && bus0.s_valid;
         if (mode == 2 && i == cut && hs) begin
            #2 sys_rst = 1'b1;
            #1 check_val("rst_async", {20'h0, g_txd, g_en, g_er, g_done, g_und}, 32'h0);
            exp_q.delete();
            bus0.s_valid = 1'b0;
            bus0.s_last  = 1'b0;
            @(posedge clk);
            #3 sys_rst = 1'b0;
            fin = 1'b1;
         end else begin
            @(posedge clk);
            #1;
            if (hs) begin
               i++;
               if (i == d.size()) begin
                  bus0.s_valid = hold;
                  bus0.s_last  = 1'b0;
                  bus0.s_data  = 8'h00;
                  fin = 1'b1;
                  @(negedge clk);
                  check_val("ready_drop", 32'(bus0.s_ready), 32'd0);
                  @(posedge clk);
                  #1;
               end else if (mode == 1 && i == cut) begin
                  bus0.s_valid = 1'b0;
                  fin = 1'b1;
               end else begin
                  bus0.s_data = d[i];
                  bus0.s_last = (i == d.size() - 1);
               end
            end
         end
         guard++;
      end
      if (!fin) begin
         check_val("send_timeout", 32'(guard), 32'd0);
         bus0.s_valid = 1'b0;
      end
   endtask

   initial begin
      bq_t d, s9, exp1, cap1;
      bit  hold, prev_hold;
      int  n, done_idx;
      bus0.s_valid = 1'b0; bus0.s_data = 8'h00; bus0.s_last = 1'b0;
      bus1.s_valid = 1'b0; bus1.s_data = 8'h00; bus1.s_last = 1'b0;
      sys_rst = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_txd", {24'h0, g_txd}, 32'h0);
      check_val("rst_en", 32'(g_en), 32'd0);
      check_val("rst_er", 32'(g_er), 32'd0);
      check_val("rst_done", 32'(g_done), 32'd0);
      check_val("rst_und", 32'(g_und), 32'd0);
      check_val("rst_ready", 32'(bus0.s_ready), 32'd0);
      @(posedge clk);
      #1 sys_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // "123456789" through the unpadded instance: known CRC-32 CBF43926.
      for (int i = 0; i < 9; i++) s9.push_back(8'h31 + 8'(i));
      for (int i = 0; i < 7; i++) exp1.push_back(8'h55);
      exp1.push_back(8'hD5);
      foreach (s9[i]) exp1.push_back(s9[i]);
      exp1.push_back(8'h26); exp1.push_back(8'h39); exp1.push_back(8'hF4); exp1.push_back(8'hCB);
      done_idx = -1;
      fork
         begin : drv1
            int i1 = 0;
            bit hs1;
            bus1.s_valid = 1'b1; bus1.s_data = s9[0]; bus1.s_last = 1'b0;
            for (int g = 0; g < 100 && i1 < 9; g++) begin
               @(negedge clk);
               hs1 = bus1.s_ready && bus1.s_valid;
               @(posedge clk);
               #1;
               if (hs1) begin
                  i1++;
                  if (i1 < 9) begin
                     bus1.s_data = s9[i1];
                     bus1.s_last = (i1 == 8);
                  end else begin
                     bus1.s_valid = 1'b0;
                     bus1.s_last  = 1'b0;
                  end
               end
            end
         end
         begin : cap
            repeat (60) begin
               @(negedge clk);
               if (g1_en) begin
                  cap1.push_back(g1_txd);
                  if (g1_done) done_idx = cap1.size() - 1;
               end
            end
         end
      join
      check_val("crc9_len", 32'(cap1.size()), 32'd21);
      check_val("crc9_done", 32'(done_idx), 32'd20);
      for (int i = 0; i < 21; i++) begin
         check_val($sformatf("crc9_b%0d", i), (i < cap1.size()) ? {24'h0, cap1[i]} : 32'hFFFF_FFFF, {24'h0, exp1[i]});
      end
      @(posedge clk);
      #1;

      // 14-byte header + 4 payload bytes: padded to 60.
      rand_bytes(18, d); push_exp(d, 0, 0, -1); send_frame(d, 0, 0, 1'b0, 1'b1);
      repeat (30) @(posedge clk);
      #1;
      // 1500 bytes, then back-to-back with s_valid held through the gap.
      rand_bytes(1500, d); push_exp(d, 0, 0, -1); send_frame(d, 0, 0, 1'b1, 1'b0);
      rand_bytes(64, d); push_exp(d, 0, 0, IFG); send_frame(d, 0, 0, 1'b0, 1'b0);
      repeat (30) @(posedge clk);
      #1;
      // Underrun after 20 accepted bytes.
      rand_bytes(40, d); push_exp(d, 1, 20, -1); send_frame(d, 1, 20, 1'b0, 1'b0);
      repeat (30) @(posedge clk);
      #1;
      // One-byte frame first, then random lengths and random back-to-back.
      prev_hold = 1'b0;
      for (int k = 0; k < 6; k++) begin
         n = (k == 0) ? 1 : int'($urandom_range(1, 120));
         hold = 1'($urandom_range(0, 1));
         rand_bytes(n, d);
         push_exp(d, 0, 0, prev_hold ? IFG : -1);
         send_frame(d, 0, 0, hold, 1'b0);
         if (!hold) begin
            repeat (30) @(posedge clk);
            #1;
         end
         prev_hold = hold;
      end
      bus0.s_valid = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      // Asynchronous reset mid-DATA, then a clean frame.
      rand_bytes(50, d); push_exp(d, 2, 10, -1); send_frame(d, 2, 10, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      rand_bytes(70, d); push_exp(d, 0, 0, -1); send_frame(d, 0, 0, 1'b0, 1'b1);

      for (int w = 0; w < 3000 && exp_q.size() > 0; w++) @(negedge clk);
      repeat (20) @(negedge clk);
      check_val("drain", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/eth_tx_fcs_framer.md
Name: eth_tx_fcs_framer

Overview:
Transmit-side framing stage that sits directly upstream of the per-byte CRC32 step function and drives it. It accepts a byte stream containing the MAC header and payload, then emits a complete GMII frame: preamble, SFD, data, zero padding to the minimum length, FCS, and the inter-frame gap. It owns the running CRC register and one CRC32 step instance, and it supplies that instance's data_in, pre_crc and crc_en inputs.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes sent before the SFD
MIN_FRAME, 60, minimum data+pad bytes before the FCS; 0 or 1 disables padding
IFG_CYCLES, 12, idle cycles held after the last FCS byte

Ports:
eth_tx_clk  in  1  byte clock (125 MHz GMII)
sys_rst  in  1  asynchronous, active-high reset
s_data  in  8  upstream byte (destination MAC first)
s_valid  in  1  s_data valid
s_last  in  1  marks the final upstream byte of the frame
s_ready  out  1  byte accepted when s_valid&s_ready
gmii_txd  out  8  transmit byte, registered
gmii_tx_en  out  1  transmit enable, registered
gmii_tx_er  out  1  transmit error, registered
tx_done  out  1  one-cycle pulse on the last FCS byte
tx_underrun  out  1  one-cycle pulse when a frame is aborted

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high on sys_rst.
- Reset values: all outputs 0; state=IDLE; crc_reg=32'hFFFFFFFF; counters 0. A reset mid-frame truncates the frame immediately, with no FCS sent.
- All GMII outputs are registered. s_ready is combinational and equals (state==DATA).
- IDLE: gmii_tx_en=0. If s_valid=1, go to PREAMBLE and load crc_reg=FFFFFFFF. No byte is consumed in this state. The first 0x55 appears on gmii_txd one cycle after s_valid is sampled.
- PREAMBLE: drive 0x55 for PREAMBLE_LEN cycles, then go to SFD.
- SFD: drive 0xD5 for 1 cycle, then go to DATA.
- DATA: each cycle with s_valid=1:
  - Output s_data.
  - Update crc_reg = step(bitrev(s_data), crc_reg) with crc_en=1.
  - Increment byte_cnt. byte_cnt is 11 bits and saturates at 2047.
  - On s_last: if byte_cnt+1 < MIN_FRAME go to PAD, else go to FCS.
- DATA underrun: if s_valid=0 in DATA, drive gmii_tx_en=1, gmii_tx_er=1 and txd=0x00 for one cycle. Pulse tx_underrun, skip FCS, and go to IFG.
- PAD: drive 0x00 and CRC it like a data byte. Continue until byte_cnt reaches MIN_FRAME, then go to FCS. s_ready=0 throughout.
- FCS: 4 cycles, k=0..3. gmii_txd = ~bitrev(crc_reg[31-8k -: 8]), where bitrev maps bit7<->bit0. crc_reg is frozen during FCS. tx_done pulses with k=3. Then go to IFG.
- IFG: gmii_tx_en=0, gmii_tx_er=0, txd=0 for IFG_CYCLES cycles, then return to IDLE. s_valid held high during IFG waits; it is not consumed.
- crc_en to the step function is 1 only in DATA (on an accepted byte) and in PAD; otherwise 0. crc_reg updates only when crc_en=1.
- The CRC and step-function output are combinational in the same cycle. crc_reg is registered, so the final CRC is available in the cycle after the last data/pad byte, which is exactly when FCS k=0 is driven.
- Wire length: frame length on the wire = 8 + max(N, MIN_FRAME) + 4 bytes, where N = upstream byte count. gmii_tx_en is high continuously from the first preamble byte to the last FCS byte.
- A one-byte frame (s_last on the first DATA byte) is legal and is padded.

Test Plan:
- MIN_FRAME=1; send ASCII "123456789" contiguously -> txd = 7×55, D5, 31..39, then 26 39 F4 CB; tx_en high for 21 cycles; tx_done on the CB cycle.
- Default params; send a 14-byte header plus 4 bytes -> 42 bytes of 0x00 pad follow; FCS matches a software CRC-32 over 60 bytes; receiver residue over data+FCS = C704DD7B.
- 1500-byte payload with random bytes -> no pad; FCS matches the model; s_ready deasserts after the s_last handshake; 12 idle cycles follow before the next preamble.
- Drop s_valid for 1 cycle at byte 20 -> gmii_tx_er=1 for one cycle with tx_en=1; tx_underrun pulses; no FCS; IFG follows, then IDLE.
- Back-to-back frames with s_valid held high -> exactly IFG_CYCLES idle cycles between frames; crc_reg is reinitialised so the second FCS is independent of the first.
- Assert sys_rst asynchronously mid-DATA -> outputs 0 immediately; after release, the next frame starts cleanly with a correct FCS.
